// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator: key codes, operator codes,
// the ALU divide-by-zero code and the key-entry FSM state encoding.
package calc_pkg;

    localparam logic [3:0] KEY_EQ   = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;

    localparam logic [3:0] OP_PLUS  = 4'd12;
    localparam logic [3:0] OP_MINUS = 4'd13;
    localparam logic [3:0] OP_MULT  = 4'd14;
    localparam logic [3:0] OP_DIV   = 4'd15;

    localparam logic [15:0] NAN_CODE = 16'h0BAB;

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'd0,
        ST_ENTER_B  = 2'd1,
        ST_EXEC     = 2'd2,
        ST_SHOW_RES = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return k >= OP_PLUS;
    endfunction

endpackage

// File: rtl/calc_digit_reg.sv
// BCD operand shift register with a saturating digit counter,
// leading-zero suppression, synchronous clear, restart and parallel load.
module calc_digit_reg #(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load_en,
    input  logic          restart,
    input  logic          shift_en,
    input  logic [3:0]    digit,
    input  logic [W-1:0]  load_val,
    output logic [W-1:0]  value,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next operand value: clear > load > restart with one digit > shift in a digit.
    always_comb begin
        // NOTE: defaulting every output first keeps this block free of inferred latches.
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (load_en) begin
            // A loaded result counts as a full operand.
            value_d = load_val;
            cnt_d   = CW'(DIGITS);
        end else if (restart) begin
            value_d = {{(W-4){1'b0}}, digit};
            cnt_d   = (digit != 4'd0) ? CW'(1) : '0;
        end else if (shift_en && (cnt_q != CW'(DIGITS)) &&
                     !((value_q == '0) && (digit == 4'd0))) begin
            value_d = {value_q[W-5:0], digit};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Operand state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value = value_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/calc_key_entry.sv
// Keypad-entry controller in front of the BCD ALU: builds operands num1/num2
// and the operator from key events, strobes exe on '=', and selects disp.
// Build option: define CALC_RESULT_CHAIN_EN to let an operator key pressed
// while a result is shown continue the calculation with that result as num1.
module calc_key_entry #(
    parameter  int                DIGITS   = 4,
    parameter  int                EXE_HOLD = 2,
    parameter  logic [4*DIGITS-1:0] NAN_CODE = (4*DIGITS)'(calc_pkg::NAN_CODE),
    localparam int                W        = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic [W-1:0] res_in,
    output logic [W-1:0] num1,
    output logic [W-1:0] num2,
    output logic [3:0]   op,
    output logic         exe,
    output logic [W-1:0] disp,
    output logic [1:0]   state
);
    import calc_pkg::*;

    localparam int CW = $clog2(DIGITS + 1);
    localparam int HW = $clog2(EXE_HOLD + 1);

`ifdef CALC_RESULT_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic          exe_q, exe_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          key_digit, key_op, key_eq, key_clr;
    logic          a_shift, a_restart, chain_go, b_clr, b_shift;
    logic [CW-1:0] b_cnt, a_cnt_unused;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_op    = key_valid && is_op(key_code);
    assign key_eq    = key_valid && (key_code == KEY_EQ);
    assign key_clr   = key_valid && (key_code == KEY_CLR);

    assign a_shift   = key_digit && (state_q == ST_ENTER_A);
    assign a_restart = key_digit && (state_q == ST_SHOW_RES);
    assign chain_go  = CHAIN_EN && key_op && (state_q == ST_SHOW_RES) && (res_in != NAN_CODE);
    assign b_clr     = key_clr || a_restart || chain_go || (key_op && (state_q == ST_ENTER_A));
    assign b_shift   = key_digit && (state_q == ST_ENTER_B);

    calc_digit_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (key_clr),
        .load_en  (chain_go),
        .restart  (a_restart),
        .shift_en (a_shift),
        .digit    (key_code),
        .load_val (res_in),
        .value    (num1),
        .cnt      (a_cnt_unused)
    );

    calc_digit_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .load_en  (1'b0),
        .restart  (1'b0),
        .shift_en (b_shift),
        .digit    (key_code),
        .load_val ('0),
        .value    (num2),
        .cnt      (b_cnt)
    );

    // FSM next state, operator latch and exe hold counter; clear overrides everything.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exe_d   = exe_q;
        hold_d  = hold_q;
        if (key_clr) begin
            state_d = ST_ENTER_A;
            op_d    = OP_PLUS;
            exe_d   = 1'b0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (key_op) begin
                        op_d    = key_code;
                        state_d = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (key_op && (b_cnt == '0)) begin
                        op_d = key_code;
                    end else if (key_eq) begin
                        state_d = ST_EXEC;
                        exe_d   = 1'b1;
                        hold_d  = HW'(1);
                    end
                end
                ST_EXEC: begin
                    if (hold_q == HW'(EXE_HOLD)) begin
                        state_d = ST_SHOW_RES;
                        exe_d   = 1'b0;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                ST_SHOW_RES: begin
                    if (a_restart) begin
                        state_d = ST_ENTER_A;
                    end else if (chain_go) begin
                        op_d    = key_code;
                        state_d = ST_ENTER_B;
                    end
                end
                default: state_d = ST_ENTER_A;
            endcase
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ENTER_A;
            op_q    <= OP_PLUS;
            exe_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            exe_q   <= exe_d;
            hold_q  <= hold_d;
        end
    end

    // Display shows the operand being typed, or the ALU result once executing.
    always_comb begin
        disp = res_in;
        case (state_q)
            ST_ENTER_A: disp = num1;
            ST_ENTER_B: disp = (b_cnt != '0) ? num2 : num1;
            default:    disp = res_in;
        endcase
    end

    assign op    = op_q;
    assign exe   = exe_q;
    assign state = state_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Testbench for calc_key_entry: directed vector table, hand-written chain
// sequence, and randomized keys checked against a decimal reference model.
module tb_calc_key_entry;

    localparam int DIGITS   = 4;
    localparam int EXE_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] res_in = 16'h0000;
    logic [15:0] num1, num2, disp;
    logic [3:0]  op;
    logic        exe;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    calc_key_entry #(.DIGITS(DIGITS), .EXE_HOLD(EXE_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .res_in    (res_in),
        .num1      (num1),
        .num2      (num2),
        .op        (op),
        .exe       (exe),
        .disp      (disp),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Behavioural BCD ALU: samples the operands on the rising edge of exe.
    function automatic logic [15:0] alu(input logic [15:0] a_b, b_b, input logic [3:0] o);
        int a, b;
        a = bcd2int(a_b);
        b = bcd2int(b_b);
        case (o)
            4'd12:   return int2bcd((a + b) % 10000);
            4'd13:   return int2bcd((a - b + 10000) % 10000);
            4'd14:   return int2bcd((a * b) % 10000);
            default: return (b == 0) ? 16'h0BAB : int2bcd(a / b);
        endcase
    endfunction

    always @(posedge exe) res_in <= alu(num1, num2, op);

    // Reference model: decimal operands, digit counts and a phase number.
    int m_st, m_a, m_an, m_b, m_bn, m_op, m_left;

    task automatic model_reset();
        m_st = 0; m_a = 0; m_an = 0; m_b = 0; m_bn = 0; m_op = 12; m_left = 0;
    endtask

    task automatic model_step(input bit r_n, input bit kv, input int k, input logic [15:0] res);
        bit dig, opk;
        dig = kv && (k <= 9);
        opk = kv && (k >= 12);
        if (!r_n || (kv && k == 11)) begin
            model_reset();
        end else begin
            case (m_st)
                0: begin
                    if (dig && m_an < DIGITS && !(m_a == 0 && k == 0)) begin
                        m_a = m_a * 10 + k; m_an++;
                    end else if (opk) begin
                        m_op = k; m_b = 0; m_bn = 0; m_st = 1;
                    end
                end
                1: begin
                    if (dig && m_bn < DIGITS && !(m_b == 0 && k == 0)) begin
                        m_b = m_b * 10 + k; m_bn++;
                    end else if (opk && m_bn == 0) begin
                        m_op = k;
                    end else if (kv && k == 10) begin
                        m_st = 2; m_left = EXE_HOLD;
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) m_st = 3;
                end
                default: begin
                    if (dig) begin
                        m_a = k; m_an = (k != 0) ? 1 : 0; m_b = 0; m_bn = 0; m_st = 0;
                    end
`ifdef CALC_RESULT_CHAIN_EN
                    else if (opk && res != 16'h0BAB) begin
                        m_a = bcd2int(res); m_an = DIGITS; m_op = k; m_b = 0; m_bn = 0; m_st = 1;
                    end
`endif
                end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the negedge, model at the posedge, sample at the next negedge.
    task automatic tick(input bit r_n, input bit kv, input int k);
        logic [15:0] res_snap;
        rst_n     = r_n;
        key_valid = kv;
        key_code  = 4'(k);
        res_snap  = res_in;
        @(posedge clk);
        model_step(r_n, kv, k, res_snap);
        #1;
        rst_n     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        @(negedge clk);
    endtask

    task automatic check_model();
        logic [15:0] exp_disp;
        if (m_st == 0)      exp_disp = int2bcd(m_a);
        else if (m_st == 1) exp_disp = (m_bn > 0) ? int2bcd(m_b) : int2bcd(m_a);
        else                exp_disp = res_in;
        check("rnd_num1",  32'(num1),  32'(int2bcd(m_a)));
        check("rnd_num2",  32'(num2),  32'(int2bcd(m_b)));
        check("rnd_op",    32'(op),    32'(m_op));
        check("rnd_exe",   32'(exe),   32'(m_st == 2));
        check("rnd_state", 32'(state), 32'(m_st));
        check("rnd_disp",  32'(disp),  32'(exp_disp));
    endtask

    typedef struct {
        bit          r_n;
        bit          kv;
        int          key;
        logic [15:0] n1;
        logic [15:0] n2;
        logic [3:0]  op;
        bit          exe;
        logic [1:0]  st;
        logic [15:0] disp;
    } vec_t;

    function automatic vec_t v(input bit r, input bit kv, input int k, input int n1, input int n2,
                               input int o, input bit e, input int st, input int d);
        vec_t x;
        x.r_n = r; x.kv = kv; x.key = k; x.n1 = 16'(n1); x.n2 = 16'(n2);
        x.op = 4'(o); x.exe = e; x.st = 2'(st); x.disp = 16'(d);
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        model_reset();

        // Directed table: reset, operand entry, saturation, leading zeros, div by zero, clear.
        vecs.push_back(v(0,0,0,  'h0000,'h0000,12,0,0,'h0000));
        vecs.push_back(v(1,1,1,  'h0001,'h0000,12,0,0,'h0001));
        vecs.push_back(v(1,1,2,  'h0012,'h0000,12,0,0,'h0012));
        vecs.push_back(v(1,1,12, 'h0012,'h0000,12,0,1,'h0012));
        vecs.push_back(v(1,1,3,  'h0012,'h0003,12,0,1,'h0003));
        vecs.push_back(v(1,1,4,  'h0012,'h0034,12,0,1,'h0034));
        vecs.push_back(v(1,1,10, 'h0012,'h0034,12,1,2,'h0046));
        vecs.push_back(v(1,1,10, 'h0012,'h0034,12,1,2,'h0046));
        vecs.push_back(v(1,0,0,  'h0012,'h0034,12,0,3,'h0046));
        vecs.push_back(v(1,1,10, 'h0012,'h0034,12,0,3,'h0046));
        vecs.push_back(v(1,1,9,  'h0009,'h0000,12,0,0,'h0009));
        vecs.push_back(v(1,1,8,  'h0098,'h0000,12,0,0,'h0098));
        vecs.push_back(v(1,1,7,  'h0987,'h0000,12,0,0,'h0987));
        vecs.push_back(v(1,1,6,  'h9876,'h0000,12,0,0,'h9876));
        vecs.push_back(v(1,1,5,  'h9876,'h0000,12,0,0,'h9876));
        vecs.push_back(v(1,1,10, 'h9876,'h0000,12,0,0,'h9876));
        vecs.push_back(v(1,1,11, 'h0000,'h0000,12,0,0,'h0000));
        vecs.push_back(v(1,1,0,  'h0000,'h0000,12,0,0,'h0000));
        vecs.push_back(v(1,1,0,  'h0000,'h0000,12,0,0,'h0000));
        vecs.push_back(v(1,1,7,  'h0007,'h0000,12,0,0,'h0007));
        vecs.push_back(v(1,1,11, 'h0000,'h0000,12,0,0,'h0000));
        vecs.push_back(v(1,1,5,  'h0005,'h0000,12,0,0,'h0005));
        vecs.push_back(v(1,1,15, 'h0005,'h0000,15,0,1,'h0005));
        vecs.push_back(v(1,1,10, 'h0005,'h0000,15,1,2,'h0BAB));
        vecs.push_back(v(1,0,0,  'h0005,'h0000,15,1,2,'h0BAB));
        vecs.push_back(v(1,0,0,  'h0005,'h0000,15,0,3,'h0BAB));
        vecs.push_back(v(1,1,12, 'h0005,'h0000,15,0,3,'h0BAB));
        vecs.push_back(v(1,1,4,  'h0004,'h0000,15,0,0,'h0004));
        vecs.push_back(v(1,1,12, 'h0004,'h0000,12,0,1,'h0004));
        vecs.push_back(v(1,1,13, 'h0004,'h0000,13,0,1,'h0004));
        vecs.push_back(v(1,1,2,  'h0004,'h0002,13,0,1,'h0002));
        vecs.push_back(v(1,1,10, 'h0004,'h0002,13,1,2,'h0002));
        vecs.push_back(v(1,0,0,  'h0004,'h0002,13,1,2,'h0002));
        vecs.push_back(v(1,0,0,  'h0004,'h0002,13,0,3,'h0002));
        vecs.push_back(v(1,1,1,  'h0001,'h0000,13,0,0,'h0001));
        vecs.push_back(v(1,1,12, 'h0001,'h0000,12,0,1,'h0001));
        vecs.push_back(v(1,1,2,  'h0001,'h0002,12,0,1,'h0002));
        vecs.push_back(v(1,1,13, 'h0001,'h0002,12,0,1,'h0002));
        vecs.push_back(v(1,1,10, 'h0001,'h0002,12,1,2,'h0003));
        vecs.push_back(v(1,1,11, 'h0000,'h0000,12,0,0,'h0000));
        vecs.push_back(v(1,1,5,  'h0005,'h0000,12,0,0,'h0005));
        vecs.push_back(v(0,1,7,  'h0000,'h0000,12,0,0,'h0000));

        @(negedge clk);
        foreach (vecs[i]) begin
            tick(vecs[i].r_n, vecs[i].kv, vecs[i].key);
            check($sformatf("vec%0d_num1", i),  32'(num1),  32'(vecs[i].n1));
            check($sformatf("vec%0d_num2", i),  32'(num2),  32'(vecs[i].n2));
            check($sformatf("vec%0d_op", i),    32'(op),    32'(vecs[i].op));
            check($sformatf("vec%0d_exe", i),   32'(exe),   32'(vecs[i].exe));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_disp", i),  32'(disp),  32'(vecs[i].disp));
        end

        // Operator key while a valid result is shown: chains only when the option is built in.
        tick(0,0,0);
        tick(1,1,1); tick(1,1,2); tick(1,1,12); tick(1,1,3); tick(1,1,4); tick(1,1,10);
        tick(1,0,0); tick(1,0,0);
        check("chain_pre_state", 32'(state), 32'd3);
        check("chain_pre_disp",  32'(disp),  32'h0046);
        tick(1,1,13);
`ifdef CALC_RESULT_CHAIN_EN
        check("chain_num1",  32'(num1),  32'h0046);
        check("chain_num2",  32'(num2),  32'h0000);
        check("chain_op",    32'(op),    32'd13);
        check("chain_state", 32'(state), 32'd1);
        check("chain_disp",  32'(disp),  32'h0046);
`else
        check("chain_num1",  32'(num1),  32'h0012);
        check("chain_num2",  32'(num2),  32'h0034);
        check("chain_op",    32'(op),    32'd12);
        check("chain_state", 32'(state), 32'd3);
        check("chain_disp",  32'(disp),  32'h0046);
`endif

        // Randomized keys against the reference model.
        tick(0,0,0);
        check_model();
        for (int n = 0; n < 3000; n++) begin
            int sel, k;
            bit r_n, kv;
            r_n = ($urandom_range(0, 199) != 0);
            kv  = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 19);
            if (sel < 10)      k = $urandom_range(0, 9);
            else if (sel < 13) k = 10;
            else if (sel < 14) k = 11;
            else               k = 12 + $urandom_range(0, 3);
            tick(r_n, kv, k);
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
